// File: rtl/ddr_sched_pkg.sv
// ddr_sched_pkg
//   Shared definitions for the DDR row command scheduler.
//   - BEAT_BYTES / BEAT_LSB : AXI beat size in bytes and its log2.
//   - sched_state_e         : scheduler FSM state encoding.
//   - is_beat_aligned()     : true when the low BEAT_LSB bits of a byte
//                             count are zero (a whole number of beats).
package ddr_sched_pkg;

   localparam int BEAT_BYTES = 32;
   localparam int BEAT_LSB   = $clog2(BEAT_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAITIDLE,
      S_ISSUE,
      S_GUARD,
      S_WAITROW,
      S_DONE
   } sched_state_e;

   function automatic logic is_beat_aligned(input logic [BEAT_LSB-1:0] low_bits);
      return (low_bits == '0);
   endfunction

endpackage

// File: rtl/ddr_row_cmd_sched.sv
// ddr_row_cmd_sched
//   Expands one 2-D transfer descriptor into one mover command per row.
//   Each row is issued only when the mover reports idle, and the mover's
//   idle is ignored for one guard cycle after each command because it
//   falls a cycle late.
//
//   Handshake: a descriptor transfers on a clock edge where desc_valid and
//   desc_ready are both 1. desc_ready is 1 only in S_IDLE; desc_valid at
//   any other time is ignored.
//
//   Ports
//     clk, rst          : clock, asynchronous active-high reset
//     desc_*            : descriptor (base, stride, row bytes, rows, dir, size)
//     abort             : finish after the row currently in flight
//     mover_idle        : idle status from the mover
//     ddr_st_addr_out,
//     ddr_len, cmd_type,
//     axi_size          : command fields, held between strobes
//     ddr_conf          : one-cycle command strobe
//     row_idx           : index of the row being issued
//     busy, done        : descriptor in progress / one-cycle completion pulse
//     desc_err          : sticky bad-length flag, cleared on the next accept
//
//   All outputs except desc_ready are registered and decoded from the
//   current state, so they trail the state register by one cycle.
module ddr_row_cmd_sched
   import ddr_sched_pkg::*;
#(
   parameter int C_AXI_ADDR_WIDTH = 64,
   parameter int SINGLE_LEN       = 24,
   parameter int ROW_CNT_W        = 16,
   parameter int STRIDE_W         = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        desc_valid,
   output logic                        desc_ready,
   input  logic [C_AXI_ADDR_WIDTH-1:0] desc_base,
   input  logic [STRIDE_W-1:0]         desc_stride,
   input  logic [SINGLE_LEN-1:0]       desc_row_bytes,
   input  logic [ROW_CNT_W-1:0]        desc_rows,
   input  logic                        desc_cmd_type,
   input  logic [2:0]                  desc_axi_size,
   input  logic                        abort,
   input  logic                        mover_idle,
   output logic [C_AXI_ADDR_WIDTH-1:0] ddr_st_addr_out,
   output logic [SINGLE_LEN-1:0]       ddr_len,
   output logic                        ddr_conf,
   output logic                        cmd_type,
   output logic [2:0]                  axi_size,
   output logic [ROW_CNT_W-1:0]        row_idx,
   output logic                        busy,
   output logic                        done,
   output logic                        desc_err
);

   localparam int AW = C_AXI_ADDR_WIDTH;

   sched_state_e          state_q, state_d;

   // Latched descriptor and working state
   logic [STRIDE_W-1:0]   stride_q, stride_d;
   logic [SINGLE_LEN-1:0] row_bytes_q, row_bytes_d;
   logic [ROW_CNT_W-1:0]  rows_q, rows_d;
   logic                  dir_q, dir_d;
   logic [2:0]            size_q, size_d;
   logic [AW-1:0]         cur_addr_q, cur_addr_d;
   logic                  abort_seen_q, abort_seen_d;

   // Registered outputs
   logic [AW-1:0]         addr_out_q, addr_out_d;
   logic [SINGLE_LEN-1:0] len_out_q, len_out_d;
   logic                  conf_q, conf_d;
   logic                  cmd_type_q, cmd_type_d;
   logic [2:0]            axi_size_q, axi_size_d;
   logic [ROW_CNT_W-1:0]  row_idx_q, row_idx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  in_busy_state;
   logic                  stop_req;

   assign in_busy_state = (state_q == S_WAITIDLE) || (state_q == S_ISSUE) ||
                          (state_q == S_GUARD)    || (state_q == S_WAITROW);
   // An abort in the current cycle counts the same as one seen earlier.
   assign stop_req      = abort || abort_seen_q;

   always_comb begin
      state_d      = state_q;
      stride_d     = stride_q;
      row_bytes_d  = row_bytes_q;
      rows_d       = rows_q;
      dir_d        = dir_q;
      size_d       = size_q;
      cur_addr_d   = cur_addr_q;
      abort_seen_d = abort_seen_q | (abort & in_busy_state);
      row_idx_d    = row_idx_q;
      err_d        = err_q;

      // Outputs follow the current state one cycle later.
      conf_d     = (state_q == S_ISSUE);
      done_d     = (state_q == S_DONE);
      busy_d     = in_busy_state;
      addr_out_d = addr_out_q;
      len_out_d  = len_out_q;
      cmd_type_d = cmd_type_q;
      axi_size_d = axi_size_q;

      case (state_q)
         S_IDLE: begin
            if (desc_valid) begin
               stride_d     = desc_stride;
               row_bytes_d  = desc_row_bytes;
               rows_d       = desc_rows;
               dir_d        = desc_cmd_type;
               size_d       = desc_axi_size;
               cur_addr_d   = desc_base;
               row_idx_d    = '0;
               abort_seen_d = 1'b0;
               err_d        = 1'b0;
               if (desc_rows == '0) begin
                  state_d = S_DONE;
               end else if ((desc_row_bytes == '0) ||
                            !is_beat_aligned(desc_row_bytes[BEAT_LSB-1:0])) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAITIDLE;
               end
            end
         end
         S_WAITIDLE: begin
            if (stop_req) begin
               state_d = S_DONE;
            end else if (mover_idle) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            addr_out_d = cur_addr_q;
            len_out_d  = row_bytes_q;
            cmd_type_d = dir_q;
            axi_size_d = size_q;
            state_d    = S_GUARD;
         end
         S_GUARD: begin
            state_d = S_WAITROW;
         end
         S_WAITROW: begin
            if (mover_idle) begin
               if (stop_req || (row_idx_q == rows_q - ROW_CNT_W'(1))) begin
                  state_d = S_DONE;
               end else begin
                  row_idx_d  = row_idx_q + ROW_CNT_W'(1);
                  // Stride is zero-extended; address wrap is silent.
                  cur_addr_d = cur_addr_q + {{(AW-STRIDE_W){1'b0}}, stride_q};
                  state_d    = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         stride_q     <= '0;
         row_bytes_q  <= '0;
         rows_q       <= '0;
         dir_q        <= 1'b0;
         size_q       <= '0;
         cur_addr_q   <= '0;
         abort_seen_q <= 1'b0;
         addr_out_q   <= '0;
         len_out_q    <= '0;
         conf_q       <= 1'b0;
         cmd_type_q   <= 1'b0;
         axi_size_q   <= '0;
         row_idx_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         stride_q     <= stride_d;
         row_bytes_q  <= row_bytes_d;
         rows_q       <= rows_d;
         dir_q        <= dir_d;
         size_q       <= size_d;
         cur_addr_q   <= cur_addr_d;
         abort_seen_q <= abort_seen_d;
         addr_out_q   <= addr_out_d;
         len_out_q    <= len_out_d;
         conf_q       <= conf_d;
         cmd_type_q   <= cmd_type_d;
         axi_size_q   <= axi_size_d;
         row_idx_q    <= row_idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign desc_ready      = (state_q == S_IDLE);
   assign ddr_st_addr_out = addr_out_q;
   assign ddr_len         = len_out_q;
   assign ddr_conf        = conf_q;
   assign cmd_type        = cmd_type_q;
   assign axi_size        = axi_size_q;
   assign row_idx         = row_idx_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign desc_err        = err_q;

endmodule

// File: tb/tb_ddr_row_cmd_sched.sv
// tb_ddr_row_cmd_sched
//   Directed bench for ddr_row_cmd_sched. A simple mover model drops idle
//   the cycle after each ddr_conf and raises it again MOVER_T cycles later.
//   A negedge monitor logs every command strobe and counts done pulses.
module tb_ddr_row_cmd_sched;

   localparam int AW      = 64;
   localparam int LW      = 24;
   localparam int RW      = 16;
   localparam int SW      = 32;
   localparam int MOVER_T = 20;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          desc_valid;
   logic          desc_ready;
   logic [AW-1:0] desc_base;
   logic [SW-1:0] desc_stride;
   logic [LW-1:0] desc_row_bytes;
   logic [RW-1:0] desc_rows;
   logic          desc_cmd_type;
   logic [2:0]    desc_axi_size;
   logic          abort;
   logic          mover_idle;
   logic [AW-1:0] ddr_st_addr_out;
   logic [LW-1:0] ddr_len;
   logic          ddr_conf;
   logic          cmd_type;
   logic [2:0]    axi_size;
   logic [RW-1:0] row_idx;
   logic          busy;
   logic          done;
   logic          desc_err;

   ddr_row_cmd_sched dut (
      .clk             (clk),
      .rst             (rst),
      .desc_valid      (desc_valid),
      .desc_ready      (desc_ready),
      .desc_base       (desc_base),
      .desc_stride     (desc_stride),
      .desc_row_bytes  (desc_row_bytes),
      .desc_rows       (desc_rows),
      .desc_cmd_type   (desc_cmd_type),
      .desc_axi_size   (desc_axi_size),
      .abort           (abort),
      .mover_idle      (mover_idle),
      .ddr_st_addr_out (ddr_st_addr_out),
      .ddr_len         (ddr_len),
      .ddr_conf        (ddr_conf),
      .cmd_type        (cmd_type),
      .axi_size        (axi_size),
      .row_idx         (row_idx),
      .busy            (busy),
      .done            (done),
      .desc_err        (desc_err)
   );

   // ---------------- mover model ----------------
   logic idle_m;
   logic force_low;
   int   mv_cnt;
   assign mover_idle = idle_m & ~force_low;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_m <= 1'b1;
         mv_cnt <= 0;
      end else if (ddr_conf) begin
         idle_m <= 1'b0;
         mv_cnt <= MOVER_T;
      end else if (mv_cnt != 0) begin
         mv_cnt <= mv_cnt - 1;
         if (mv_cnt == 1) idle_m <= 1'b1;
      end
   end

   // ---------------- monitor ----------------
   int          conf_cnt = 0;
   int          done_cnt = 0;
   int          bad_conf = 0;
   logic [63:0] addr_log[$];
   logic [63:0] len_log[$];
   logic [63:0] cmd_log[$];
   logic [63:0] idx_log[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (ddr_conf) begin
            conf_cnt++;
            addr_log.push_back(64'(ddr_st_addr_out));
            len_log.push_back(64'(ddr_len));
            cmd_log.push_back(64'(cmd_type));
            idx_log.push_back(64'(row_idx));
            if (!mover_idle) bad_conf++;
         end
         if (done) done_cnt++;
      end
   end

   // ---------------- scoreboard ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_desc(input logic [63:0] base, input logic [31:0] stride,
                            input logic [23:0] bytes, input logic [15:0] rows,
                            input logic dir, input logic [2:0] size);
      @(negedge clk);
      desc_base      = base;
      desc_stride    = stride;
      desc_row_bytes = bytes;
      desc_rows      = rows;
      desc_cmd_type  = dir;
      desc_axi_size  = size;
      desc_valid     = 1'b1;
      @(posedge clk);
      #1 desc_valid  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int start;
      bit seen;
      start = done_cnt;
      seen  = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done_cnt != start) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, 64'(seen), 64'd1);
   endtask

   task automatic wait_conf(input string tag, input int target, input int bound);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (conf_cnt >= target) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, 64'(seen), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int s_conf;
      int s_done;

      rst            = 1'b1;
      desc_valid     = 1'b0;
      desc_base      = '0;
      desc_stride    = '0;
      desc_row_bytes = '0;
      desc_rows      = '0;
      desc_cmd_type  = 1'b0;
      desc_axi_size  = '0;
      abort          = 1'b0;
      force_low      = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_conf", 64'(ddr_conf), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_addr", 64'(ddr_st_addr_out), 64'd0);
      check("rst_err", 64'(desc_err), 64'd0);
      check("rst_ready", 64'(desc_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // 1: three-row read
      s_conf = conf_cnt;
      s_done = done_cnt;
      send_desc(64'h1000, 32'h400, 24'd256, 16'd3, 1'b0, 3'd5);
      @(negedge clk);
      check("t1_ready_low", 64'(desc_ready), 64'd0);
      wait_done("t1_done_seen", 200);
      check("t1_conf_count", 64'(conf_cnt - s_conf), 64'd3);
      check("t1_addr0", addr_log[s_conf], 64'h1000);
      check("t1_addr1", addr_log[s_conf+1], 64'h1400);
      check("t1_addr2", addr_log[s_conf+2], 64'h1800);
      check("t1_len", len_log[s_conf+2], 64'd256);
      check("t1_cmd", cmd_log[s_conf], 64'd0);
      check("t1_idx0", idx_log[s_conf], 64'd0);
      check("t1_idx2", idx_log[s_conf+2], 64'd2);
      repeat (3) @(negedge clk);
      check("t1_done_once", 64'(done_cnt - s_done), 64'd1);
      check("t1_no_conf_busy", 64'(bad_conf), 64'd0);
      check("t1_busy_end", 64'(busy), 64'd0);

      // 2a: zero rows -> done two cycles after the accept cycle, no command
      s_conf = conf_cnt;
      send_desc(64'h7000, 32'h100, 24'd64, 16'd0, 1'b0, 3'd5);
      @(negedge clk);
      check("t2_done_early", 64'(done), 64'd0);
      @(negedge clk);
      check("t2_done", 64'(done), 64'd1);
      check("t2_err0", 64'(desc_err), 64'd0);
      @(negedge clk);
      check("t2_done_pulse", 64'(done), 64'd0);
      check("t2_no_conf", 64'(conf_cnt - s_conf), 64'd0);

      // 2b: unaligned length -> error, no command
      send_desc(64'h7000, 32'h100, 24'd100, 16'd2, 1'b0, 3'd5);
      wait_done("t2b_done_seen", 20);
      check("t2b_err", 64'(desc_err), 64'd1);
      check("t2b_no_conf", 64'(conf_cnt - s_conf), 64'd0);

      // 2c: valid descriptor clears the error
      send_desc(64'h8000, 32'h40, 24'd64, 16'd1, 1'b0, 3'd5);
      @(negedge clk);
      check("t2c_err_clr", 64'(desc_err), 64'd0);
      wait_done("t2c_done_seen", 100);
      check("t2c_conf_count", 64'(conf_cnt - s_conf), 64'd1);
      check("t2c_addr", addr_log[s_conf], 64'h8000);

      // 3: abort during row 1 of five
      s_conf = conf_cnt;
      send_desc(64'h2000, 32'h100, 24'd32, 16'd5, 1'b1, 3'd4);
      wait_conf("t3_row1_seen", s_conf + 2, 200);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("t3_done_seen", 100);
      repeat (3) @(negedge clk);
      check("t3_conf_count", 64'(conf_cnt - s_conf), 64'd2);
      check("t3_addr1", addr_log[s_conf+1], 64'h2100);
      check("t3_cmd", cmd_log[s_conf+1], 64'd1);
      check("t3_row_idx", 64'(row_idx), 64'd1);
      check("t3_size", 64'(axi_size), 64'd4);

      // 4: address wrap
      s_conf = conf_cnt;
      send_desc(64'hFFFF_FFFF_FFFF_FF00, 32'h200, 24'd64, 16'd2, 1'b0, 3'd5);
      wait_done("t4_done_seen", 200);
      check("t4_conf_count", 64'(conf_cnt - s_conf), 64'd2);
      check("t4_addr0", addr_log[s_conf], 64'hFFFF_FFFF_FFFF_FF00);
      check("t4_addr1", addr_log[s_conf+1], 64'h100);
      check("t4_err", 64'(desc_err), 64'd0);

      // 5: mover busy at accept; extra valid while busy is ignored
      s_conf = conf_cnt;
      force_low = 1'b1;
      send_desc(64'h4000, 32'h80, 24'd96, 16'd1, 1'b0, 3'd3);
      repeat (3) @(negedge clk);
      check("t5_ready_busy", 64'(desc_ready), 64'd0);
      desc_base  = 64'h9999_0000;
      desc_valid = 1'b1;
      @(negedge clk);
      desc_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("t5_no_conf_held", 64'(conf_cnt - s_conf), 64'd0);
      force_low = 1'b0;
      @(negedge clk);
      check("t5_conf_not_yet", 64'(ddr_conf), 64'd0);
      @(negedge clk);
      check("t5_conf_two", 64'(ddr_conf), 64'd1);
      check("t5_addr", 64'(ddr_st_addr_out), 64'h4000);
      check("t5_len", 64'(ddr_len), 64'd96);
      wait_done("t5_done_seen", 100);
      repeat (20) @(negedge clk);
      check("t5_conf_count", 64'(conf_cnt - s_conf), 64'd1);

      // 6: reset in S_WAITROW
      s_conf = conf_cnt;
      send_desc(64'h5000, 32'h1000, 24'd128, 16'd3, 1'b1, 3'd4);
      wait_conf("t6_row0_seen", s_conf + 1, 50);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_conf", 64'(ddr_conf), 64'd0);
      check("t6_rst_addr", 64'(ddr_st_addr_out), 64'd0);
      check("t6_rst_len", 64'(ddr_len), 64'd0);
      check("t6_rst_cmd", 64'(cmd_type), 64'd0);
      check("t6_rst_size", 64'(axi_size), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check("t6_ready", 64'(desc_ready), 64'd1);
      s_conf = conf_cnt;
      send_desc(64'h6000, 32'h20, 24'd32, 16'd2, 1'b0, 3'd5);
      wait_done("t6_done_seen", 200);
      check("t6_conf_count", 64'(conf_cnt - s_conf), 64'd2);
      check("t6_addr0", addr_log[s_conf], 64'h6000);
      check("t6_addr1", addr_log[s_conf+1], 64'h6020);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
